// File: rtl/seq_arith_unit.sv
// seq_arith_unit
// Multi-cycle unsigned arithmetic unit. Add and sub finish in one cycle.
// Mul (shift-add) and div (restoring) run for OPERAND_WIDTH steps behind Busy.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   A, B              W-bit unsigned operands, sampled at accept
//   ALU_FUN           00 add, 01 sub, 10 mul, 11 div
//   Arith_Enable      request, accepted only while Busy=0
//   Busy              iterative op in progress
//   Arith_Flag        one-cycle pulse, result/flags valid
//   Arith_OUT         2W-bit result, held until next completion
//   Extra_Bits        OR of the upper half of Arith_OUT
//   Carry             add carry-out / sub borrow
//   Div0              divide by zero
module seq_arith_unit #(
   parameter int OPERAND_WIDTH = 8,
   parameter int RESULT_WIDTH  = 2*OPERAND_WIDTH
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [OPERAND_WIDTH-1:0] A,
   input  logic [OPERAND_WIDTH-1:0] B,
   input  logic [1:0]               ALU_FUN,
   input  logic                     Arith_Enable,
   output logic                     Busy,
   output logic                     Arith_Flag,
   output logic [RESULT_WIDTH-1:0]  Arith_OUT,
   output logic                     Extra_Bits,
   output logic                     Carry,
   output logic                     Div0
);
   localparam int W  = OPERAND_WIDTH;
   localparam int CW = $clog2(W+1);

   typedef enum logic {IDLE, ITER} state_t;
   state_t state, state_n;

   // Working registers are shared between mul and div:
   //   mul: mcand = shifted multiplicand, mplier = multiplier (LSB first),
   //        acc = partial product
   //   div: mcand[W-1:0] = divisor, mplier = dividend (MSB first),
   //        acc = {remainder, quotient}
   logic            is_div;
   logic [CW-1:0]   cnt;
   logic [2*W-1:0]  mcand;
   logic [W-1:0]    mplier;
   logic [2*W-1:0]  acc;

   logic [2*W-1:0]  sum_ext, dif_ext, acc_mul, acc_div, acc_step, res;
   logic [W:0]      rem_sh, trial;
   logic [W-1:0]    rem_n;
   logic            qbit, done, load, carry_n, div0_n;

   assign sum_ext = {{W{1'b0}}, A} + {{W{1'b0}}, B};
   // 2W-bit subtraction wraps, giving the sign-extended two's complement
   assign dif_ext = {{W{1'b0}}, A} - {{W{1'b0}}, B};

   assign acc_mul = mplier[0] ? acc + mcand : acc;

   // remainder is always < divisor, so the shifted value fits in W+1 bits
   // and the kept value always fits back into W bits
   assign rem_sh  = {acc[2*W-1:W], mplier[W-1]};
   assign trial   = rem_sh - {1'b0, mcand[W-1:0]};
   assign qbit    = ~trial[W];
   assign rem_n   = qbit ? trial[W-1:0] : rem_sh[W-1:0];
   assign acc_div = {rem_n, acc[W-2:0], qbit};

   assign acc_step = is_div ? acc_div : acc_mul;
   assign Busy     = (state == ITER);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      done    = 1'b0;
      load    = 1'b0;
      res     = '0;
      carry_n = 1'b0;
      div0_n  = 1'b0;
      case (state)
         IDLE: if (Arith_Enable) begin
            case (ALU_FUN)
               2'b00: begin
                  done    = 1'b1;
                  res     = sum_ext;
                  carry_n = sum_ext[W];
               end
               2'b01: begin
                  done    = 1'b1;
                  res     = dif_ext;
                  carry_n = (A < B);
               end
               2'b10: begin
                  load    = 1'b1;
                  state_n = ITER;
               end
               default: begin
                  if (B == '0) begin
                     done   = 1'b1;
                     res    = {A, {W{1'b1}}};
                     div0_n = 1'b1;
                  end else begin
                     load    = 1'b1;
                     state_n = ITER;
                  end
               end
            endcase
         end
         ITER: if (cnt == CW'(1)) begin
            done    = 1'b1;
            res     = acc_step;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         Arith_Flag <= 1'b0;
         Arith_OUT  <= '0;
         Extra_Bits <= 1'b0;
         Carry      <= 1'b0;
         Div0       <= 1'b0;
         is_div     <= 1'b0;
         cnt        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         acc        <= '0;
      end else begin
         Arith_Flag <= done;
         if (done) begin
            Arith_OUT  <= res;
            Extra_Bits <= |res[2*W-1:W];
            Carry      <= carry_n;
            Div0       <= div0_n;
         end
         if (load) begin
            is_div <= ALU_FUN[0];
            cnt    <= CW'(W);
            mcand  <= {{W{1'b0}}, B};
            mplier <= A;
            acc    <= '0;
         end else if (state == ITER) begin
            cnt <= cnt - CW'(1);
            acc <= acc_step;
            if (is_div) begin
               mplier <= mplier << 1;
            end else begin
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
            end
         end
      end
   end
endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit (W=8): constant vector table,
// random ops against a behavioural model, and hand-written multi-cycle cases.
// Expected results are queued at drive time and checked on each Arith_Flag.
module tb_seq_arith_unit;
   localparam int W = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [W-1:0]  A = '0, B = '0;
   logic [1:0]    ALU_FUN = '0;
   logic          Arith_Enable = 1'b0;
   logic          Busy, Arith_Flag, Extra_Bits, Carry, Div0;
   logic [2*W-1:0] Arith_OUT;

   seq_arith_unit #(.OPERAND_WIDTH(W), .RESULT_WIDTH(2*W)) dut (
      .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
      .Arith_Enable(Arith_Enable), .Busy(Busy), .Arith_Flag(Arith_Flag),
      .Arith_OUT(Arith_OUT), .Extra_Bits(Extra_Bits), .Carry(Carry), .Div0(Div0)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  a, b;
      logic [15:0] out;
      logic        carry, div0;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] out;
      logic        carry, div0;
      int          t0, lat;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_err = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic vec_t model(logic [1:0] op, logic [7:0] a, logic [7:0] b);
      vec_t v;
      logic [15:0] s;
      v.op = op; v.a = a; v.b = b; v.carry = 1'b0; v.div0 = 1'b0;
      case (op)
         2'd0: begin s = 16'(a) + 16'(b); v.out = s; v.carry = s[8]; end
         2'd1: begin v.out = 16'(a) - 16'(b); v.carry = (a < b); end
         2'd2: v.out = 16'(a) * 16'(b);
         default: begin
            if (b == 0) begin v.out = {a, 8'hFF}; v.div0 = 1'b1; end
            else v.out = {a % b, a / b};
         end
      endcase
      return v;
   endfunction

   function automatic bit iterative(vec_t v);
      return (v.op == 2'd2) || (v.op == 2'd3 && v.b != 0);
   endfunction

   // scoreboard: check every completion against the oldest queued expectation
   always @(negedge CLK) begin
      if (!RST && Arith_Flag) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_flag: got Arith_Flag=1 out=%0h expected no completion", Arith_OUT);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, "_out"},   Arith_OUT,  e.out);
            chk({e.name, "_carry"}, Carry,      e.carry);
            chk({e.name, "_div0"},  Div0,       e.div0);
            chk({e.name, "_xbits"}, Extra_Bits, |e.out[15:8]);
            chk({e.name, "_lat"},   cyc - e.t0, e.lat);
            chk({e.name, "_busy"},  Busy,       1'b0);
         end
      end
   end

   function automatic void push(string nm, vec_t v, int t0);
      exp_t e;
      e.name = nm; e.out = v.out; e.carry = v.carry; e.div0 = v.div0;
      e.t0 = t0; e.lat = iterative(v) ? W + 1 : 1;
      q.push_back(e);
   endfunction

   // one operation; inj>0 pulses a stray add 1+1 request that many cycles in
   task automatic run(input vec_t v, input int inj, input string nm);
      int busy_cnt;
      @(negedge CLK);
      A = v.a; B = v.b; ALU_FUN = v.op; Arith_Enable = 1'b1;
      push(nm, v, cyc);
      busy_cnt = 0;
      for (int i = 0; i < 40 && q.size() != 0; i++) begin
         @(negedge CLK);
         if (i == 0) Arith_Enable = 1'b0;
         if (inj > 0 && i == inj) begin
            ALU_FUN = 2'd0; A = 8'd1; B = 8'd1; Arith_Enable = 1'b1;
         end
         if (inj > 0 && i == inj + 1) Arith_Enable = 1'b0;
         if (Busy) busy_cnt++;
      end
      if (q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: got %0d pending expected 0", nm, q.size());
         q.delete();
      end
      chk({nm, "_busycycles"}, busy_cnt, iterative(v) ? W : 0);
   endtask

   vec_t tbl[12];

   initial begin
      int c;
      vec_t v;
      tbl[0]  = '{2'd0, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0};
      tbl[1]  = '{2'd1, 8'd3,  8'd5,  16'hFFFE, 1'b1, 1'b0};
      tbl[2]  = '{2'd1, 8'd5,  8'd3,  16'h0002, 1'b0, 1'b0};
      tbl[3]  = '{2'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0};
      tbl[4]  = '{2'd3, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0};
      tbl[5]  = '{2'd3, 8'h5A, 8'h00, 16'h5AFF, 1'b0, 1'b1};
      tbl[6]  = '{2'd0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0};
      tbl[7]  = '{2'd2, 8'h00, 8'hAB, 16'h0000, 1'b0, 1'b0};
      tbl[8]  = '{2'd3, 8'hFF, 8'h01, 16'h00FF, 1'b0, 1'b0};
      tbl[9]  = '{2'd3, 8'd7,  8'd200, 16'h0700, 1'b0, 1'b0};
      tbl[10] = '{2'd2, 8'd16, 8'd16, 16'h0100, 1'b0, 1'b0};
      tbl[11] = '{2'd1, 8'h00, 8'hFF, 16'hFF01, 1'b1, 1'b0};

      // reset state
      repeat (3) @(negedge CLK);
      chk("rst_out",   Arith_OUT,  16'h0);
      chk("rst_busy",  Busy,       1'b0);
      chk("rst_flag",  Arith_Flag, 1'b0);
      chk("rst_xbits", Extra_Bits, 1'b0);
      chk("rst_carry", Carry,      1'b0);
      chk("rst_div0",  Div0,       1'b0);
      RST = 1'b0;

      for (int i = 0; i < 12; i++) run(tbl[i], 0, $sformatf("vec%0d", i));

      // stray request mid-multiply must be ignored
      run(tbl[3], 2, "mul_inj");
      repeat (4) @(negedge CLK);
      chk("mul_inj_hold", Arith_OUT, 16'hFE01);

      // reset during step 4 of 200/7
      @(negedge CLK);
      A = 8'd200; B = 8'd7; ALU_FUN = 2'd3; Arith_Enable = 1'b1;
      @(negedge CLK);
      Arith_Enable = 1'b0;
      chk("abort_busy", Busy, 1'b1);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("abort_out",   Arith_OUT,  16'h0);
      chk("abort_busy0", Busy,       1'b0);
      chk("abort_flag",  Arith_Flag, 1'b0);
      chk("abort_xbits", Extra_Bits, 1'b0);
      chk("abort_carry", Carry,      1'b0);
      RST = 1'b0;
      repeat (12) @(negedge CLK);
      run(model(2'd0, 8'd2, 8'd3), 0, "post_abort_add");

      // back-to-back with enable held: mul 16*16 then add 1+2 at edge W+1
      @(negedge CLK);
      A = 8'd16; B = 8'd16; ALU_FUN = 2'd2; Arith_Enable = 1'b1;
      c = cyc;
      push("b2b_mul", tbl[10], c);
      push("b2b_add", model(2'd0, 8'd1, 8'd2), c + W + 1);
      @(negedge CLK);
      A = 8'd1; B = 8'd2; ALU_FUN = 2'd0;
      repeat (W + 1) @(negedge CLK);
      Arith_Enable = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge CLK);
      if (q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL b2b_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
      repeat (3) @(negedge CLK);

      // random ops against the behavioural model
      for (int i = 0; i < 16; i++) begin
         logic [1:0] op;
         logic [7:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = 8'($urandom_range(0, 255));
         b  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         v  = model(op, a, b);
         run(v, 0, $sformatf("rnd%0d", i));
      end

      repeat (3) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/seq_arith_unit.md
# seq_arith_unit

Parametrised multi-cycle arithmetic unit for the ALU datapath. It performs add, subtract, multiply and divide on OPERAND_WIDTH-bit unsigned operands. Add and subtract complete in a single cycle. Multiply (shift-add) and divide (restoring, quotient plus remainder) run iteratively with a busy/done handshake. Sticky-free status flags report carry/borrow, high-half overflow and divide-by-zero alongside each result.

## Interface
- OPERAND_WIDTH, 8: operand width W; must be ≥2.
- RESULT_WIDTH, 2*OPERAND_WIDTH: result width; must equal 2*W.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- A  in  W  operand A, unsigned.
- B  in  W  operand B, unsigned.
- ALU_FUN  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- Arith_Enable  in  1  request; accepted only when Busy=0.
- Busy  out  1  iterative operation in progress.
- Arith_Flag  out  1  one-cycle pulse: Arith_OUT and status flags are valid.
- Arith_OUT  out  2W  result; held until the next completion.
- Extra_Bits  out  1  |Arith_OUT[2W-1:W], registered at completion.
- Carry  out  1  add carry-out (bit W); sub borrow (A<B); 0 for mul/div.
- Div0  out  1  divide with B=0.

## Operation
- Reset (synchronous, RST=1 at an edge): state IDLE; Busy, Arith_Flag, Extra_Bits, Carry and Div0 all 0; Arith_OUT 0; iteration counter 0. Reset overrides any in-flight operation; the partial result is discarded.
- States:
  - IDLE: accept on Arith_Enable=1; A, B and ALU_FUN are sampled only at the accept edge.
    - Add: Arith_OUT = zero-extended A + B.
    - Sub: Arith_OUT = (A − B) mod 2^(2W), i.e. two's complement, sign-extended when negative.
    - Add, sub and divide-by-zero write the result in IDLE and stay in IDLE.
    - Mul, or div with B≠0: load the working registers, set counter=W, go to ITER.
  - ITER: one step per cycle; the counter decrements each step.
    - Mul step: if the current LSB of the multiplier is 1, add the shifted multiplicand into the accumulator; shift.
    - Div step: shift the remainder left, bringing in the next dividend bit MSB-first; trial-subtract B; if non-negative, keep the difference and set the quotient bit to 1, else set it to 0.
    - Return to IDLE on the step where counter=1, writing the result.
- Results:
  - Mul: Arith_OUT = A*B (full 2W).
  - Div: Arith_OUT = {remainder[W-1:0], quotient[W-1:0]}.
  - Div by zero: Arith_OUT = {A, all-ones}, Div0=1, no iteration.
- Flags are written only at completion, together with Arith_OUT. Div0 is 0 for every other completion. Extra_Bits is computed from the new Arith_OUT.
- Arith_Enable while Busy=1 is ignored. No queuing, no error signalled.
- Arith_Enable held high: a new operation is accepted in every cycle with Busy=0, including the cycle immediately after a completion.
- Arith_Flag is 0 in every cycle except the one after a completion edge.

## Timing
- Accept at edge 0.
- Add/sub/div0: result and flags are updated at edge 0. Arith_Flag is high for the cycle after edge 0. Busy stays 0. Latency is 1.
- Mul/div:
  - Busy goes high after edge 0.
  - Steps execute at edges 1..W.
  - Result, flags and Busy=0 are all updated at edge W.
  - Arith_Flag is high for the cycle after edge W. Latency is W+1; the next accept is possible at edge W+1.
- Reset asserted at any edge: outputs read reset values from the following cycle, and Arith_Flag is not pulsed for the aborted operation.
- No combinational path from inputs to outputs.

## Test plan
- W=8, add A=0xFF, B=0x01 -> after 1 edge: Arith_OUT=0x0100, Carry=1, Extra_Bits=1, Arith_Flag pulse 1 cycle, Busy stays 0.
- Sub A=3, B=5 -> Arith_OUT=0xFFFE, Carry=1, Extra_Bits=1; then sub A=5, B=3 -> 0x0002, Carry=0, Extra_Bits=0.
- Mul A=0xFF, B=0xFF -> Busy high for 8 cycles, Arith_OUT=0xFE01, Extra_Bits=1. A second Arith_Enable (add 1+1) at cycle 3 is ignored: exactly one Arith_Flag pulse, result stays 0xFE01.
- Div A=200, B=7 -> Arith_OUT=0x041C (rem 4, quo 28), Div0=0, latency 9 edges. Div A=0x5A, B=0 -> 0x5AFF, Div0=1, 1 edge, Busy never high.
- Reset mid-division: RST=1 at step 4 of div 200/7 -> all outputs 0, no Arith_Flag. A following add 2+3 returns 0x0005.
- Back-to-back with Arith_Enable held high: mul 16*16 then add 1+2 -> Arith_OUT=0x0100, then 0x0003 on the edge after completion; two Arith_Flag pulses.
